sp_bram_stim_gen: RTL

- Self-contained stimulus sequencer that drives the port set of a single-port BRAM under test: wclke, we, re, addr, byteen, wdata_a, addren.
- The same port set is also observed by the single-port BRAM checker.
- Runs a fixed sequence of phases: fill, read-back, byte-enable masking, same-address collision, then LFSR-random traffic. It then drains the read pipeline and flags done.
- Sits upstream of both the BRAM instance and its monitor in the simple dual/single-port RAM simulation environment.

---
 rtl/sp_bram_stim_gen.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sp_bram_stim_gen.sv
// sp_bram_stim_gen
// Stimulus sequencer for a single-port BRAM and its checker. It walks a fixed
// set of phases (fill, read-back, byte-mask write, read-back, same-address
// collision, LFSR random traffic, drain) and pulses done at the end.
//
// Handshake: start is a single-cycle request. It is accepted only while the
// sequencer is in IDLE and is ignored at every other time. busy is high for
// every cycle in which the sequence drives the BRAM. done is high for exactly
// one cycle, in the first IDLE cycle after the last drain cycle.
//
// Every output is a register loaded from next-state values, so the value on a
// port belongs to the cycle in which the BRAM samples it. The phase output
// carries the state register so that checkers can follow the FSM.
module sp_bram_stim_gen #(
  parameter int          DATA_WIDTH_A    = 16,
  parameter int          ADDR_WIDTH_A    = 4,
  parameter int          BYTEEN_WIDTH    = 2,
  parameter bit          WCLKE_POLARITY  = 1'b1,
  parameter bit          WE_POLARITY     = 1'b1,
  parameter bit          RE_POLARITY     = 1'b1,
  parameter bit          BYTEEN_POLARITY = 1'b1,
  parameter bit          ADDREN_POLARITY = 1'b1,
  parameter int          RANDOM_OPS      = 64,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          DRAIN_CYCLES    = 3
) (
  input  logic                    clk,
  input  logic                    bram_rst,
  input  logic                    start,
  output logic                    wclke,
  output logic                    we,
  output logic                    re,
  output logic [ADDR_WIDTH_A-1:0] addr,
  output logic [BYTEEN_WIDTH-1:0] byteen,
  output logic [DATA_WIDTH_A-1:0] wdata_a,
  output logic                    addren,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              phase
);

  localparam int          DEPTH      = 1 << ADDR_WIDTH_A;
  // A zero seed would lock the LFSR at zero, so it falls back to the default.
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] SWEEP_LAST = 16'(DEPTH - 1);
  localparam logic [15:0] RAND_LAST  = 16'(RANDOM_OPS - 1);
  // A drain length of zero still leaves one idle cycle before done.
  localparam logic [15:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? 16'(DRAIN_CYCLES - 1) : 16'h0000;
  localparam logic [15:0] BE_GROUPS  = 16'(BYTEEN_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_FILL  = 3'd1,
    S_R_SWEEP = 3'd2,
    S_B_MASK  = 3'd3,
    S_COLLIDE = 3'd4,
    S_RANDOM  = 3'd5,
    S_DRAIN   = 3'd6
  } state_e;

  // Sequencer state. cnt_q is the address counter in the sweep phases and the
  // cycle counter in RANDOM and DRAIN. second_q marks that the read sweep has
  // already run once, which steers its exit to COLLIDE instead of B_MASK.
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        second_q, second_d;
  logic [15:0] lfsr_q, lfsr_d;

  // Registered outputs.
  logic                    wclke_q, wclke_d;
  logic                    we_q, we_d;
  logic                    re_q, re_d;
  logic [ADDR_WIDTH_A-1:0] addr_q, addr_d;
  logic [BYTEEN_WIDTH-1:0] byteen_q, byteen_d;
  logic [DATA_WIDTH_A-1:0] wdata_q, wdata_d;
  logic                    addren_q, addren_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Active-true intent before polarity is applied.
  logic                    wclke_on, we_on, re_on, addren_on;
  logic [BYTEEN_WIDTH-1:0] be_on;

  // Byte pattern a[7:0] ^ k repeated across the data word.
  function automatic logic [DATA_WIDTH_A-1:0] byte_pattern(input logic [15:0] a,
                                                           input logic [7:0]  k);
    logic [7:0]              b;
    logic [DATA_WIDTH_A-1:0] r;
    b = a[7:0] ^ k;
    for (int i = 0; i < DATA_WIDTH_A; i++) r[i] = b[i % 8];
    return r;
  endfunction

  // 16-bit LFSR value repeated across the data word.
  function automatic logic [DATA_WIDTH_A-1:0] lfsr_pattern(input logic [15:0] l);
    logic [DATA_WIDTH_A-1:0] r;
    for (int i = 0; i < DATA_WIDTH_A; i++) r[i] = l[i % 16];
    return r;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Next-state logic: phase sequencing, counters and LFSR stepping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    second_d = second_q;
    lfsr_d   = lfsr_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_W_FILL;
          cnt_d    = 16'h0000;
          second_d = 1'b0;
        end
      end
      S_W_FILL, S_R_SWEEP, S_B_MASK, S_COLLIDE: begin
        if (cnt_q == SWEEP_LAST) begin
          cnt_d = 16'h0000;
          case (state_q)
            S_W_FILL:  state_d = S_R_SWEEP;
            S_R_SWEEP: begin
              state_d  = second_q ? S_COLLIDE : S_B_MASK;
              second_d = 1'b1;
            end
            S_B_MASK:  state_d = S_R_SWEEP;
            default:   state_d = S_RANDOM;
          endcase
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RANDOM: begin
        // The current value has driven this cycle; step to the next one.
        lfsr_d = lfsr_next(lfsr_q);
        if (cnt_q == RAND_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = 16'h0000;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 16'h0000;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'h0000;
      end
    endcase
  end

  // Output decode for the cycle being entered, from next-state values.
  always_comb begin
    wclke_on  = 1'b0;
    we_on     = 1'b0;
    re_on     = 1'b0;
    addren_on = 1'b0;
    be_on     = '0;
    addr_d    = '0;
    wdata_d   = '0;
    case (state_d)
      S_W_FILL: begin
        wclke_on  = 1'b1;
        we_on     = 1'b1;
        addren_on = 1'b1;
        be_on     = '1;
        addr_d    = cnt_d[ADDR_WIDTH_A-1:0];
        wdata_d   = byte_pattern(cnt_d, 8'hA5);
      end
      S_R_SWEEP: begin
        re_on     = 1'b1;
        addren_on = 1'b1;
        addr_d    = cnt_d[ADDR_WIDTH_A-1:0];
      end
      S_B_MASK: begin
        wclke_on  = 1'b1;
        we_on     = 1'b1;
        addren_on = 1'b1;
        addr_d    = cnt_d[ADDR_WIDTH_A-1:0];
        wdata_d   = byte_pattern(cnt_d, 8'h3C);
        // One byte group per address, rotating with the address.
        for (int i = 0; i < BYTEEN_WIDTH; i++) be_on[i] = ((cnt_d % BE_GROUPS) == 16'(i));
      end
      S_COLLIDE: begin
        wclke_on  = 1'b1;
        we_on     = 1'b1;
        re_on     = 1'b1;
        addren_on = 1'b1;
        be_on     = '1;
        addr_d    = cnt_d[ADDR_WIDTH_A-1:0];
        wdata_d   = byte_pattern(cnt_d, 8'hC3);
      end
      S_RANDOM: begin
        wclke_on  = lfsr_d[0];
        we_on     = lfsr_d[0];
        re_on     = lfsr_d[1];
        addren_on = ~lfsr_d[15];
        be_on     = lfsr_d[BYTEEN_WIDTH+7:8];
        addr_d    = lfsr_d[ADDR_WIDTH_A+1:2];
        wdata_d   = lfsr_pattern(lfsr_d);
      end
      default: begin
        addr_d = '0;
      end
    endcase
    wclke_d  = wclke_on  ? WCLKE_POLARITY  : ~WCLKE_POLARITY;
    we_d     = we_on     ? WE_POLARITY     : ~WE_POLARITY;
    re_d     = re_on     ? RE_POLARITY     : ~RE_POLARITY;
    addren_d = addren_on ? ADDREN_POLARITY : ~ADDREN_POLARITY;
    byteen_d = BYTEEN_POLARITY ? be_on : ~be_on;
    busy_d   = (state_d != S_IDLE);
  end

  // State, counter, LFSR and output registers; reset aborts any sequence.
  always_ff @(posedge clk) begin
    if (bram_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'h0000;
      second_q <= 1'b0;
      lfsr_q   <= SEED;
      wclke_q  <= ~WCLKE_POLARITY;
      we_q     <= ~WE_POLARITY;
      re_q     <= ~RE_POLARITY;
      addren_q <= ~ADDREN_POLARITY;
      byteen_q <= BYTEEN_POLARITY ? {BYTEEN_WIDTH{1'b0}} : {BYTEEN_WIDTH{1'b1}};
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      second_q <= second_d;
      lfsr_q   <= lfsr_d;
      wclke_q  <= wclke_d;
      we_q     <= we_d;
      re_q     <= re_d;
      addren_q <= addren_d;
      byteen_q <= byteen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wclke   = wclke_q;
  assign we      = we_q;
  assign re      = re_q;
  assign addr    = addr_q;
  assign byteen  = byteen_q;
  assign wdata_a = wdata_q;
  assign addren  = addren_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign phase   = state_q;

endmodule
